// File: rtl/atpg_mode_entry.sv
// Tester test-mode entry responder: synchronises TST/SCL/SDA pads, shifts in a
// 16-bit key while TST is high and raises scan/IDDQ mode enables on a match.
module atpg_mode_entry #(
  parameter logic [15:0]      KEY_SCAN = 16'hA53C,
  parameter logic [15:0]      KEY_IDDQ = 16'h5AC3,
  parameter int unsigned      TMO_W    = 12,
  parameter logic [TMO_W-1:0] TMO_MAX  = 12'd4000,
  parameter logic [7:0]       EXIT_CYC = 8'd16
) (
  input  logic       clk,
  input  logic       rstz,
  input  logic       tst_i,
  input  logic       scl_i,
  input  logic       sda_i,
  output logic       scan_mode,
  output logic       iddq_mode,
  output logic       key_err,
  output logic       busy,
  output logic [4:0] bit_cnt
);

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_SHIFT  = 3'd1,
    ST_CHECK  = 3'd2,
    ST_ACTIVE = 3'd3,
    ST_FAIL   = 3'd4
  } state_t;

  localparam logic [TMO_W-1:0] TMO_LAST  = TMO_MAX - {{(TMO_W-1){1'b0}}, 1'b1};
  localparam logic [7:0]       EXIT_LAST = EXIT_CYC - 8'd1;

  logic tst_meta_r, tst_sync_r, tst_prev_r;
  logic scl_meta_r, scl_sync_r, scl_prev_r;
  logic sda_meta_r, sda_sync_r;
  logic tst_rise_s, scl_rise_s;

  state_t           state_r, state_nx_s;
  logic [15:0]      shreg_r, shreg_nx_s;
  logic [4:0]       bit_cnt_r, bit_cnt_nx_s;
  logic [TMO_W-1:0] tmo_r, tmo_nx_s;
  logic [7:0]       exit_r, exit_nx_s;
  logic             scan_r, scan_nx_s;
  logic             iddq_r, iddq_nx_s;
  logic             key_err_r, key_err_nx_s;
  logic             busy_r, busy_nx_s;

  // Pad synchronisers and edge-history flops. The TST chain resets high so a
  // TST pad held high through reset is never mistaken for a fresh rising edge.
  always_ff @(posedge clk) begin
    if (!rstz) begin
      tst_meta_r <= 1'b1;
      tst_sync_r <= 1'b1;
      tst_prev_r <= 1'b1;
      scl_meta_r <= 1'b0;
      scl_sync_r <= 1'b0;
      scl_prev_r <= 1'b0;
      sda_meta_r <= 1'b0;
      sda_sync_r <= 1'b0;
    end else begin
      tst_meta_r <= tst_i;
      tst_sync_r <= tst_meta_r;
      tst_prev_r <= tst_sync_r;
      scl_meta_r <= scl_i;
      scl_sync_r <= scl_meta_r;
      scl_prev_r <= scl_sync_r;
      sda_meta_r <= sda_i;
      sda_sync_r <= sda_meta_r;
    end
  end

  assign tst_rise_s = tst_sync_r & ~tst_prev_r;
  assign scl_rise_s = scl_sync_r & ~scl_prev_r;

  // Next-state and next-output logic for the key-entry FSM.
  always_comb begin
    state_nx_s   = state_r;
    shreg_nx_s   = shreg_r;
    bit_cnt_nx_s = bit_cnt_r;
    tmo_nx_s     = tmo_r;
    exit_nx_s    = exit_r;
    scan_nx_s    = scan_r;
    iddq_nx_s    = iddq_r;
    key_err_nx_s = key_err_r;
    case (state_r)
      ST_IDLE: begin
        scan_nx_s    = 1'b0;
        iddq_nx_s    = 1'b0;
        key_err_nx_s = 1'b0;
        exit_nx_s    = 8'd0;
        if (tst_rise_s) begin
          state_nx_s   = ST_SHIFT;
          shreg_nx_s   = 16'h0000;
          bit_cnt_nx_s = 5'd0;
          tmo_nx_s     = {TMO_W{1'b0}};
        end else begin
          state_nx_s = ST_IDLE;
        end
      end
      ST_SHIFT: begin
        // TST falling outranks a coincident SCL rise: abort without shifting.
        if (!tst_sync_r) begin
          state_nx_s = ST_IDLE;
        end else if (scl_rise_s) begin
          shreg_nx_s   = {shreg_r[14:0], sda_sync_r};
          bit_cnt_nx_s = (bit_cnt_r < 5'd16) ? (bit_cnt_r + 5'd1) : bit_cnt_r;
          tmo_nx_s     = {TMO_W{1'b0}};
          if (bit_cnt_r >= 5'd15) begin
            state_nx_s = ST_CHECK;
          end else begin
            state_nx_s = ST_SHIFT;
          end
        end else if (tmo_r >= TMO_LAST) begin
          state_nx_s   = ST_FAIL;
          key_err_nx_s = 1'b1;
        end else begin
          tmo_nx_s = tmo_r + {{(TMO_W-1){1'b0}}, 1'b1};
        end
      end
      ST_CHECK: begin
        exit_nx_s = 8'd0;
        if (shreg_r == KEY_IDDQ) begin
          state_nx_s = ST_ACTIVE;
          scan_nx_s  = 1'b1;
          iddq_nx_s  = 1'b1;
        end else if (shreg_r == KEY_SCAN) begin
          state_nx_s = ST_ACTIVE;
          scan_nx_s  = 1'b1;
          iddq_nx_s  = 1'b0;
        end else begin
          state_nx_s   = ST_FAIL;
          scan_nx_s    = 1'b0;
          iddq_nx_s    = 1'b0;
          key_err_nx_s = 1'b1;
        end
      end
      ST_ACTIVE: begin
        // Only a sustained TST low leaves the mode; shorter glitches just rearm.
        if (tst_sync_r) begin
          exit_nx_s = 8'd0;
        end else if (exit_r >= EXIT_LAST) begin
          exit_nx_s  = 8'd0;
          scan_nx_s  = 1'b0;
          iddq_nx_s  = 1'b0;
          state_nx_s = ST_IDLE;
        end else begin
          exit_nx_s = exit_r + 8'd1;
        end
      end
      ST_FAIL: begin
        scan_nx_s = 1'b0;
        iddq_nx_s = 1'b0;
        if (!tst_sync_r) begin
          state_nx_s   = ST_IDLE;
          key_err_nx_s = 1'b0;
        end else begin
          state_nx_s   = ST_FAIL;
          key_err_nx_s = 1'b1;
        end
      end
      default: begin
        state_nx_s   = ST_IDLE;
        scan_nx_s    = 1'b0;
        iddq_nx_s    = 1'b0;
        key_err_nx_s = 1'b0;
      end
    endcase
    busy_nx_s = (state_nx_s == ST_SHIFT) || (state_nx_s == ST_CHECK);
  end

  // FSM state and registered outputs.
  always_ff @(posedge clk) begin
    if (!rstz) begin
      state_r   <= ST_IDLE;
      shreg_r   <= 16'h0000;
      bit_cnt_r <= 5'd0;
      tmo_r     <= {TMO_W{1'b0}};
      exit_r    <= 8'd0;
      scan_r    <= 1'b0;
      iddq_r    <= 1'b0;
      key_err_r <= 1'b0;
      busy_r    <= 1'b0;
    end else begin
      state_r   <= state_nx_s;
      shreg_r   <= shreg_nx_s;
      bit_cnt_r <= bit_cnt_nx_s;
      tmo_r     <= tmo_nx_s;
      exit_r    <= exit_nx_s;
      scan_r    <= scan_nx_s;
      iddq_r    <= iddq_nx_s & scan_nx_s;
      key_err_r <= key_err_nx_s;
      busy_r    <= busy_nx_s;
    end
  end

  assign scan_mode = scan_r;
  assign iddq_mode = iddq_r;
  assign key_err   = key_err_r;
  assign busy      = busy_r;
  assign bit_cnt   = bit_cnt_r;

endmodule

// File: tb/tb_atpg_mode_entry.sv
// Directed self-checking bench for atpg_mode_entry: key entry, exit filtering,
// wrong key, SCL timeout, early TST drop and reset while a mode is active.
module tb_atpg_mode_entry;

  logic       clk = 1'b0;
  logic       rstz;
  logic       tst_i;
  logic       scl_i;
  logic       sda_i;
  logic       scan_mode;
  logic       iddq_mode;
  logic       key_err;
  logic       busy;
  logic [4:0] bit_cnt;

  int n_cmp = 0;
  int n_mis = 0;

  atpg_mode_entry dut (
    .clk       (clk),
    .rstz      (rstz),
    .tst_i     (tst_i),
    .scl_i     (scl_i),
    .sda_i     (sda_i),
    .scan_mode (scan_mode),
    .iddq_mode (iddq_mode),
    .key_err   (key_err),
    .busy      (busy),
    .bit_cnt   (bit_cnt)
  );

  always #5 clk = ~clk;

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // One bit per 8 clk: SDA set with SCL low, then SCL rises and is held.
  task automatic shift_bits(input logic [15:0] key, input int n);
    for (int i = 0; i < n; i++) begin
      sda_i = key[15-i];
      scl_i = 1'b0;
      step(4);
      scl_i = 1'b1;
      step(4);
    end
  endtask

  task automatic tst_enter();
    tst_i = 1'b1;
    step(4);
  endtask

  task automatic tst_leave(input int n);
    tst_i = 1'b0;
    scl_i = 1'b0;
    step(n);
  endtask

  task automatic test_reset();
    rstz = 1'b0; tst_i = 1'b0; scl_i = 1'b0; sda_i = 1'b0;
    step(3);
    rstz = 1'b1;
    step(2);
    if (scan_mode !== 1'b0) begin $display("FAIL rst_scan: got %0b want 0", scan_mode); n_mis++; end n_cmp++;
    if (iddq_mode !== 1'b0) begin $display("FAIL rst_iddq: got %0b want 0", iddq_mode); n_mis++; end n_cmp++;
    if (key_err !== 1'b0) begin $display("FAIL rst_err: got %0b want 0", key_err); n_mis++; end n_cmp++;
    if (busy !== 1'b0) begin $display("FAIL rst_busy: got %0b want 0", busy); n_mis++; end n_cmp++;
    if (bit_cnt !== 5'd0) begin $display("FAIL rst_cnt: got %0d want 0", bit_cnt); n_mis++; end n_cmp++;
  endtask

  task automatic test_scan_key();
    tst_enter();
    if (busy !== 1'b1) begin $display("FAIL scan_busy: got %0b want 1", busy); n_mis++; end n_cmp++;
    shift_bits(16'hA53C, 15);
    if (bit_cnt !== 5'd15) begin $display("FAIL scan_cnt15: got %0d want 15", bit_cnt); n_mis++; end n_cmp++;
    sda_i = 1'b0; scl_i = 1'b0;
    step(4);
    scl_i = 1'b1;
    step(3);  // 16th rise has been captured; CHECK cycle now
    if (scan_mode !== 1'b0) begin $display("FAIL scan_early: got %0b want 0", scan_mode); n_mis++; end n_cmp++;
    if (bit_cnt !== 5'd16) begin $display("FAIL scan_cnt16: got %0d want 16", bit_cnt); n_mis++; end n_cmp++;
    step(1);
    if (scan_mode !== 1'b1) begin $display("FAIL scan_on: got %0b want 1", scan_mode); n_mis++; end n_cmp++;
    if (iddq_mode !== 1'b0) begin $display("FAIL scan_iddq: got %0b want 0", iddq_mode); n_mis++; end n_cmp++;
    if (key_err !== 1'b0) begin $display("FAIL scan_err: got %0b want 0", key_err); n_mis++; end n_cmp++;
    if (busy !== 1'b0) begin $display("FAIL scan_busy_done: got %0b want 0", busy); n_mis++; end n_cmp++;
    tst_leave(24);
    if (scan_mode !== 1'b0) begin $display("FAIL scan_exit: got %0b want 0", scan_mode); n_mis++; end n_cmp++;
  endtask

  task automatic test_iddq_exit();
    tst_enter();
    shift_bits(16'h5AC3, 16);
    if (scan_mode !== 1'b1 || iddq_mode !== 1'b1) begin $display("FAIL iddq_on: got scan=%0b iddq=%0b want 1/1", scan_mode, iddq_mode); n_mis++; end n_cmp++;
    tst_i = 1'b0;
    step(10);
    tst_i = 1'b1;
    step(4);
    if (scan_mode !== 1'b1 || iddq_mode !== 1'b1) begin $display("FAIL iddq_glitch: got scan=%0b iddq=%0b want 1/1", scan_mode, iddq_mode); n_mis++; end n_cmp++;
    tst_i = 1'b0;
    step(17);  // synchronised low for 15 cycles
    if (scan_mode !== 1'b1 || iddq_mode !== 1'b1) begin $display("FAIL iddq_hold15: got scan=%0b iddq=%0b want 1/1", scan_mode, iddq_mode); n_mis++; end n_cmp++;
    step(1);
    if (scan_mode !== 1'b0 || iddq_mode !== 1'b0) begin $display("FAIL iddq_exit16: got scan=%0b iddq=%0b want 0/0", scan_mode, iddq_mode); n_mis++; end n_cmp++;
    step(2);
    tst_enter();
    if (busy !== 1'b1 || bit_cnt !== 5'd0) begin $display("FAIL iddq_idle: got busy=%0b cnt=%0d want 1/0", busy, bit_cnt); n_mis++; end n_cmp++;
    tst_leave(6);
  endtask

  task automatic test_wrong_key();
    tst_enter();
    shift_bits(16'hA53D, 16);
    if (key_err !== 1'b1) begin $display("FAIL wrong_err: got %0b want 1", key_err); n_mis++; end n_cmp++;
    if (scan_mode !== 1'b0 || iddq_mode !== 1'b0) begin $display("FAIL wrong_modes: got scan=%0b iddq=%0b want 0/0", scan_mode, iddq_mode); n_mis++; end n_cmp++;
    if (busy !== 1'b0) begin $display("FAIL wrong_busy: got %0b want 0", busy); n_mis++; end n_cmp++;
    shift_bits(16'hA53C, 4);
    if (key_err !== 1'b1 || busy !== 1'b0 || bit_cnt !== 5'd16) begin $display("FAIL wrong_ignore: got err=%0b busy=%0b cnt=%0d want 1/0/16", key_err, busy, bit_cnt); n_mis++; end n_cmp++;
    tst_leave(4);
    if (key_err !== 1'b0) begin $display("FAIL wrong_clear: got %0b want 0", key_err); n_mis++; end n_cmp++;
    tst_enter();
    shift_bits(16'hA53C, 16);
    if (scan_mode !== 1'b1 || key_err !== 1'b0) begin $display("FAIL wrong_retry: got scan=%0b err=%0b want 1/0", scan_mode, key_err); n_mis++; end n_cmp++;
    tst_leave(24);
  endtask

  task automatic test_timeout();
    tst_enter();
    shift_bits(16'hFFFF, 5);
    step(3990);
    if (busy !== 1'b1 || key_err !== 1'b0) begin $display("FAIL tmo_early: got busy=%0b err=%0b want 1/0", busy, key_err); n_mis++; end n_cmp++;
    step(20);
    if (key_err !== 1'b1) begin $display("FAIL tmo_err: got %0b want 1", key_err); n_mis++; end n_cmp++;
    if (busy !== 1'b0) begin $display("FAIL tmo_busy: got %0b want 0", busy); n_mis++; end n_cmp++;
    if (bit_cnt !== 5'd5) begin $display("FAIL tmo_cnt: got %0d want 5", bit_cnt); n_mis++; end n_cmp++;
    tst_leave(6);
  endtask

  task automatic test_early_drop();
    tst_enter();
    shift_bits(16'hA53C, 9);
    tst_leave(4);
    if (busy !== 1'b0 || key_err !== 1'b0) begin $display("FAIL drop_idle: got busy=%0b err=%0b want 0/0", busy, key_err); n_mis++; end n_cmp++;
    if (bit_cnt !== 5'd9) begin $display("FAIL drop_cnt: got %0d want 9", bit_cnt); n_mis++; end n_cmp++;
    tst_enter();
    if (busy !== 1'b1 || bit_cnt !== 5'd0) begin $display("FAIL drop_restart: got busy=%0b cnt=%0d want 1/0", busy, bit_cnt); n_mis++; end n_cmp++;
    tst_leave(6);
  endtask

  task automatic test_reset_active();
    tst_enter();
    shift_bits(16'hA53C, 16);
    if (scan_mode !== 1'b1) begin $display("FAIL ract_on: got %0b want 1", scan_mode); n_mis++; end n_cmp++;
    rstz = 1'b0;
    step(1);
    if (scan_mode !== 1'b0 || iddq_mode !== 1'b0 || key_err !== 1'b0 || busy !== 1'b0 || bit_cnt !== 5'd0)
      begin $display("FAIL ract_clear: got scan=%0b iddq=%0b err=%0b busy=%0b cnt=%0d want all 0", scan_mode, iddq_mode, key_err, busy, bit_cnt); n_mis++; end n_cmp++;
    rstz = 1'b1;
    shift_bits(16'hA53C, 16);
    if (scan_mode !== 1'b0 || busy !== 1'b0) begin $display("FAIL ract_noreentry: got scan=%0b busy=%0b want 0/0", scan_mode, busy); n_mis++; end n_cmp++;
    tst_leave(4);
    tst_enter();
    shift_bits(16'hA53C, 16);
    if (scan_mode !== 1'b1) begin $display("FAIL ract_reentry: got %0b want 1", scan_mode); n_mis++; end n_cmp++;
    tst_leave(24);
  endtask

  initial begin
    test_reset();
    test_scan_key();
    test_iddq_exit();
    test_wrong_key();
    test_timeout();
    test_early_drop();
    test_reset_active();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end

endmodule
